// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle MIPS main control unit driving datapath enables, mux selects and ALUOp.
// Ports:
//   CLK, RST (async active-low)             clock and reset
//   Opcode[5:0], Funct[5:0]                 instruction fields IR[31:26], IR[5:0]
//   Mem_Ready                               memory access completes this cycle
//   PCWrite..Illegal_Op                     single-bit datapath controls
//   RegDst, MemtoReg, ALUSrcB, PCSource     2-bit mux selects
//   ALUOp[2:0]                              operation code for the ALU controller
module main_control_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Mem_Ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       ExtOp,
  output logic       Illegal_Op,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp
);
  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC,
    R_WB, BRANCH, JUMP, JAL, JR, I_EXEC, I_WB
  } state_t;
  state_t state_q, state_d, dec_state;
  // Dispatch target from DECODE; FETCH here means the opcode is illegal.
  always_comb begin
    dec_state = FETCH;
    case (Opcode)
      6'b100011, 6'b101011: dec_state = MEM_ADDR;
      6'b000000:            dec_state = (Funct == 6'b001000) ? JR : R_EXEC;
      6'b000100, 6'b000101: dec_state = BRANCH;
      6'b000010:            dec_state = JUMP;
      6'b000011:            dec_state = JAL;
      6'b001000, 6'b001001, 6'b001010,
      6'b001100, 6'b001101, 6'b001110: dec_state = I_EXEC;
      default:              dec_state = FETCH;
    endcase
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:      state_d = FETCH;
      FETCH:     state_d = Mem_Ready ? DECODE : FETCH;
      DECODE:    state_d = dec_state;
      MEM_ADDR:  state_d = (Opcode == 6'b100011) ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_d = Mem_Ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = Mem_Ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      I_EXEC:    state_d = I_WB;
      default:   state_d = FETCH;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state_q <= INIT;
    else      state_q <= state_d;
  // Outputs decode from state; FETCH write enables follow Mem_Ready in the same
  // cycle, so they cannot be registered. INIT (held by reset) decodes to all zero.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ExtOp       = 1'b0;
    Illegal_Op  = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 3'b000;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = Mem_Ready;
        PCWrite = Mem_Ready;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        Illegal_Op = (dec_state == FETCH);
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (Opcode == 6'b000101);
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end
      JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (Opcode == 6'b001010) ? 3'b011 :
                  (Opcode == 6'b001100) ? 3'b100 :
                  (Opcode == 6'b001101) ? 3'b101 :
                  (Opcode == 6'b001110) ? 3'b110 : 3'b000;
        ExtOp   = (Opcode == 6'b001100) || (Opcode == 6'b001101) || (Opcode == 6'b001110);
      end
      I_WB: RegWrite = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: directed-vector bench for main_control_fsm.
module tb_main_control_fsm;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Mem_Ready = 1'b1;
  logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic       RegWrite, ALUSrcA, ExtOp, Illegal_Op;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  int n_vec = 0;
  int n_err = 0;
  main_control_fsm dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Mem_Ready(Mem_Ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ExtOp(ExtOp), .Illegal_Op(Illegal_Op), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp)
  );
  always #5 CLK = ~CLK;
  logic [21:0] obs;
  assign obs = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                RegWrite, ALUSrcA, ExtOp, Illegal_Op, RegDst, MemtoReg, ALUSrcB,
                PCSource, ALUOp};
  localparam logic [21:0] PCW = 22'd1 << 21, PCWC = 22'd1 << 20, BNE = 22'd1 << 19;
  localparam logic [21:0] IORD = 22'd1 << 18, MRD = 22'd1 << 17, MWR = 22'd1 << 16;
  localparam logic [21:0] IRW = 22'd1 << 15, RW = 22'd1 << 14, SRCA = 22'd1 << 13;
  localparam logic [21:0] EXT = 22'd1 << 12, ILL = 22'd1 << 11;
  localparam logic [21:0] RD_RD = 22'd1 << 9, RD_31 = 22'd2 << 9;
  localparam logic [21:0] MTR_MDR = 22'd1 << 7, MTR_PC = 22'd2 << 7;
  localparam logic [21:0] SB_4 = 22'd1 << 5, SB_IMM = 22'd2 << 5, SB_SH = 22'd3 << 5;
  localparam logic [21:0] PS_OUT = 22'd1 << 3, PS_J = 22'd2 << 3, PS_A = 22'd3 << 3;
  localparam logic [21:0] E_FETCH = MRD | SB_4 | IRW | PCW;
  localparam logic [21:0] E_FWAIT = MRD | SB_4;
  localparam logic [21:0] E_DEC   = SB_SH;
  localparam logic [21:0] E_MADDR = SRCA | SB_IMM;
  localparam logic [21:0] E_MRD   = MRD | IORD;
  localparam logic [21:0] E_MWB   = RW | MTR_MDR;
  localparam logic [21:0] E_MWR   = MWR | IORD;
  localparam logic [21:0] E_REXE  = SRCA | 22'd2;
  localparam logic [21:0] E_RWB   = RW | RD_RD;
  localparam logic [21:0] E_BEQ   = SRCA | 22'd1 | PCWC | PS_OUT;
  localparam logic [21:0] E_JUMP  = PCW | PS_J;
  localparam logic [21:0] E_JAL   = PCW | PS_J | RW | RD_31 | MTR_PC;
  localparam logic [21:0] E_JR    = PCW | PS_A;
  localparam logic [21:0] E_IWB   = RW;
  task automatic check(input string tag, input logic [21:0] exp);
    #1;
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [21:0] exp);
    check(tag, exp);
    @(posedge CLK);
    #2;
  endtask
  initial begin
    #2;
    check("reset", 22'd0);
    @(posedge CLK); #2;
    check("reset_held", 22'd0);
    RST = 1'b1;
    step("init", 22'd0);
    Opcode = 6'b100011;
    step("lw_fetch", E_FETCH);
    step("lw_decode", E_DEC);
    step("lw_maddr", E_MADDR);
    step("lw_mread", E_MRD);
    step("lw_mwb", E_MWB);
    Mem_Ready = 1'b0;
    step("lww_fwait1", E_FWAIT);
    step("lww_fwait2", E_FWAIT);
    Mem_Ready = 1'b1;
    step("lww_fetch", E_FETCH);
    step("lww_decode", E_DEC);
    step("lww_maddr", E_MADDR);
    Mem_Ready = 1'b0;
    step("lww_rwait1", E_MRD);
    step("lww_rwait2", E_MRD);
    step("lww_rwait3", E_MRD);
    Mem_Ready = 1'b1;
    step("lww_mread", E_MRD);
    step("lww_mwb", E_MWB);
    Opcode = 6'b101011;
    step("sw_fetch", E_FETCH);
    step("sw_decode", E_DEC);
    step("sw_maddr", E_MADDR);
    step("sw_mwrite", E_MWR);
    Opcode = 6'b000000; Funct = 6'b100000;
    step("add_fetch", E_FETCH);
    Mem_Ready = 1'b0;
    step("add_decode", E_DEC);
    step("add_rexec", E_REXE);
    step("add_rwb", E_RWB);
    Mem_Ready = 1'b1;
    Funct = 6'b001000;
    step("jr_fetch", E_FETCH);
    step("jr_decode", E_DEC);
    step("jr_jr", E_JR);
    Opcode = 6'b000101; Funct = 6'b000000;
    step("bne_fetch", E_FETCH);
    step("bne_decode", E_DEC);
    step("bne_branch", E_BEQ | BNE);
    Opcode = 6'b000100;
    step("beq_fetch", E_FETCH);
    step("beq_decode", E_DEC);
    step("beq_branch", E_BEQ);
    Opcode = 6'b000010;
    step("j_fetch", E_FETCH);
    step("j_decode", E_DEC);
    step("j_jump", E_JUMP);
    Opcode = 6'b000011;
    step("jal_fetch", E_FETCH);
    step("jal_decode", E_DEC);
    step("jal_jal", E_JAL);
    Opcode = 6'b001100;
    step("andi_fetch", E_FETCH);
    step("andi_decode", E_DEC);
    step("andi_iexec", E_MADDR | 22'd4 | EXT);
    step("andi_iwb", E_IWB);
    Opcode = 6'b001101;
    step("ori_fetch", E_FETCH);
    step("ori_decode", E_DEC);
    step("ori_iexec", E_MADDR | 22'd5 | EXT);
    step("ori_iwb", E_IWB);
    Opcode = 6'b001110;
    step("xori_fetch", E_FETCH);
    step("xori_decode", E_DEC);
    step("xori_iexec", E_MADDR | 22'd6 | EXT);
    step("xori_iwb", E_IWB);
    Opcode = 6'b001010;
    step("slti_fetch", E_FETCH);
    step("slti_decode", E_DEC);
    step("slti_iexec", E_MADDR | 22'd3);
    step("slti_iwb", E_IWB);
    Opcode = 6'b001001;
    step("addiu_fetch", E_FETCH);
    step("addiu_decode", E_DEC);
    step("addiu_iexec", E_MADDR);
    step("addiu_iwb", E_IWB);
    Opcode = 6'b111111;
    step("ill_fetch", E_FETCH);
    step("ill_decode", E_DEC | ILL);
    Opcode = 6'b101011;
    step("sw2_fetch", E_FETCH);
    step("sw2_decode", E_DEC);
    step("sw2_maddr", E_MADDR);
    Mem_Ready = 1'b0;
    step("sw2_wait1", E_MWR);
    check("sw2_wait2", E_MWR);
    RST = 1'b0;
    check("rst_async", 22'd0);
    @(posedge CLK); #2;
    check("rst_low", 22'd0);
    RST = 1'b1;
    Mem_Ready = 1'b1;
    step("rst_init", 22'd0);
    check("rst_fetch", E_FETCH);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multi-cycle main control unit of the MIPS core, the producer side of the ALUOp interface consumed by the ALU controller. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, plus the 3-bit ALUOp code, from the current state and the instruction opcode. Memory accesses wait on a single-bit ready handshake.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0]; used only to detect JR (001000).
- Mem_Ready  in  1  memory has completed the current access this cycle.
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtOp, Illegal_Op  out  1 each.
  - ExtOp: 1 = zero-extend the immediate.
  - Illegal_Op: 1-cycle flag for an illegal opcode.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- ALUSrcB  out  2  00 B, 01 const 4, 10 extended imm, 11 extended imm<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
- ALUOp  out  3  ALUOp codes:
  - 000 add
  - 001 subtract
  - 010 R-type, decode Funct
  - 011 set-less-than
  - 100 and
  - 101 or
  - 110 xor
  - 111 never driven

## Operation
- State is a 4-bit register with these states: INIT, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, JAL, JR, I_EXEC, I_WB.
- Outputs are Moore-decoded from the state; exceptions are the Mem_Ready-gated enables and the Opcode-dependent fields listed below. Any output not listed for a state is 0.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=000, IRWrite=PCWrite=Mem_Ready. Holds while Mem_Ready=0, else goes to DECODE.
- DECODE: ALUSrcB=11, ALUOp=000 (branch target computed into ALUOut). Next state by Opcode:
  - 100011 (lw), 101011 (sw) → MEM_ADDR
  - 000000 with Funct=001000 → JR; any other 000000 → R_EXEC
  - 000100 (beq), 000101 (bne) → BRANCH
  - 000010 (j) → JUMP
  - 000011 (jal) → JAL
  - 001000, 001001, 001010, 001100, 001101, 001110 → I_EXEC
  - any other opcode: Illegal_Op=1, next state FETCH
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Holds until Mem_Ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=01, RegDst=00. Next FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until Mem_Ready, then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next R_WB.
- R_WB: RegWrite=1, RegDst=01, MemtoReg=00. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, BranchNE=(Opcode==000101). Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. Next FETCH.
- JR: PCWrite=1, PCSource=11. Next FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10. Next I_WB. ALUOp and ExtOp by Opcode:
  - addi/addiu: ALUOp 000, ExtOp 0
  - slti: ALUOp 011, ExtOp 0
  - andi: ALUOp 100, ExtOp 1
  - ori: ALUOp 101, ExtOp 1
  - xori: ALUOp 110, ExtOp 1
- I_WB: RegWrite=1, RegDst=00, MemtoReg=00. Next FETCH.
- Opcode and Funct are sampled only in DECODE, MEM_ADDR, BRANCH and I_EXEC; IR is stable in those states.

## Timing
- RST low forces state to INIT immediately, in any state, including mid-wait on Mem_Ready. While RST is low all outputs are 0.
- The first FETCH is the first rising edge after RST deasserts.
- Cycles per instruction with Mem_Ready held high:
  - lw 5, sw 4
  - R-type 4, I-type 4
  - beq/bne 3, j 3, jal 3, jr 3
  - illegal opcode 2
- Each cycle of Mem_Ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- During a FETCH wait, IRWrite and PCWrite stay 0 and MemRead stays 1.
- Mem_Ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
- Illegal_Op is high for exactly the one DECODE cycle.

## Test plan
- Reset then lw (Opcode 100011), Mem_Ready=1 → states INIT, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; MEM_WB drives RegWrite=1, MemtoReg=01.
- lw with Mem_Ready low for 2 cycles in FETCH and 3 in MEM_READ → 10 cycles total; IRWrite pulses once, only on the ready cycle.
- R-type add (000000/100000) → ALUOp=010 in R_EXEC, RegDst=01 in R_WB. Funct=001000 → JR with PCSource=11, PCWrite=1.
- bne (000101) → BRANCH with ALUOp=001, PCWriteCond=1, BranchNE=1. beq → BranchNE=0.
- andi/ori/xori/slti → ALUOp 100/101/110/011 respectively; ExtOp=1 only for the first three.
- Opcode 111111 → Illegal_Op=1 for one cycle, then FETCH. RST pulsed low during a MEM_WRITE wait → all outputs 0 at once, then FETCH after release.
